// File: rtl/atr_io_ctrl_pkg.sv
// Shared constants for the daughterboard ATR I/O control block:
// serial register addresses and the TX/RX state encoding.
package atr_io_ctrl_pkg;

    localparam logic [6:0] FR_IO_0          = 7'd20;
    localparam logic [6:0] FR_IO_1          = 7'd21;
    localparam logic [6:0] FR_ATR_MASK_0    = 7'd22;
    localparam logic [6:0] FR_ATR_TXVAL_0   = 7'd23;
    localparam logic [6:0] FR_ATR_RXVAL_0   = 7'd24;
    localparam logic [6:0] FR_ATR_MASK_1    = 7'd25;
    localparam logic [6:0] FR_ATR_TXVAL_1   = 7'd26;
    localparam logic [6:0] FR_ATR_RXVAL_1   = 7'd27;
    localparam logic [6:0] FR_ATR_TX_DELAY  = 7'd28;
    localparam logic [6:0] FR_ATR_RX_DELAY  = 7'd29;

    typedef enum logic [1:0] {
        ST_RX       = 2'd0,
        ST_TX_DELAY = 2'd1,
        ST_TX       = 2'd2,
        ST_RX_DELAY = 2'd3
    } atr_state_e;

    // Upper half of the write word selects which low-half bits are replaced.
    function automatic logic [15:0] masked_merge(input logic [15:0] old_val,
                                                 input logic [31:0] wdata);
        return (old_val & ~wdata[31:16]) | (wdata[15:0] & wdata[31:16]);
    endfunction

endpackage

// File: rtl/atr_io_ctrl_atr_delay.sv
// Switch-over delay counter: load, decrement, terminal count at 1.
// Shared by the TX_DELAY and RX_DELAY states.
module atr_delay #(
    parameter int DELAY_W = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [DELAY_W-1:0] load_val,
    input  logic               dec,
    output logic               tc
);

    logic [DELAY_W-1:0] cnt_q;
    logic [DELAY_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_q - DELAY_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == DELAY_W'(1));

endmodule

// File: rtl/atr_io_ctrl.sv
// Daughterboard I/O bank output generator: per-bit manual value or ATR
// TX/RX value, with programmable TX/RX switch-over delays.
module atr_io_ctrl
    import atr_io_ctrl_pkg::*;
#(
    parameter int DELAY_W = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    input  logic        enable_tx,
    input  logic        tx_empty,
    output logic [15:0] reg_0,
    output logic [15:0] reg_1,
    output logic [1:0]  atr_state
);

    logic [15:0] io_0_q, io_0_d, io_1_q, io_1_d;
    logic [15:0] mask_0_q, mask_0_d, mask_1_q, mask_1_d;
    logic [15:0] txval_0_q, txval_0_d, txval_1_q, txval_1_d;
    logic [15:0] rxval_0_q, rxval_0_d, rxval_1_q, rxval_1_d;
    logic [DELAY_W-1:0] tx_delay_q, tx_delay_d, rx_delay_q, rx_delay_d;
    logic [15:0] reg_0_q, reg_0_d, reg_1_q, reg_1_d;
    atr_state_e  state_q, state_d;

    logic               transmit;
    logic               cnt_load;
    logic [DELAY_W-1:0] cnt_load_val;
    logic               cnt_dec;
    logic               cnt_tc;
    logic               use_tx;

    assign transmit = enable_tx & ~tx_empty;

    always_comb begin
        io_0_d     = io_0_q;
        io_1_d     = io_1_q;
        mask_0_d   = mask_0_q;
        mask_1_d   = mask_1_q;
        txval_0_d  = txval_0_q;
        txval_1_d  = txval_1_q;
        rxval_0_d  = rxval_0_q;
        rxval_1_d  = rxval_1_q;
        tx_delay_d = tx_delay_q;
        rx_delay_d = rx_delay_q;
        if (serial_strobe) begin
            case (serial_addr)
                FR_IO_0:         io_0_d     = masked_merge(io_0_q, serial_data);
                FR_IO_1:         io_1_d     = masked_merge(io_1_q, serial_data);
                FR_ATR_MASK_0:   mask_0_d   = serial_data[15:0];
                FR_ATR_TXVAL_0:  txval_0_d  = serial_data[15:0];
                FR_ATR_RXVAL_0:  rxval_0_d  = serial_data[15:0];
                FR_ATR_MASK_1:   mask_1_d   = serial_data[15:0];
                FR_ATR_TXVAL_1:  txval_1_d  = serial_data[15:0];
                FR_ATR_RXVAL_1:  rxval_1_d  = serial_data[15:0];
                FR_ATR_TX_DELAY: tx_delay_d = serial_data[DELAY_W-1:0];
                FR_ATR_RX_DELAY: rx_delay_d = serial_data[DELAY_W-1:0];
                default: ;
            endcase
        end
    end

    // A zero delay skips the delay state entirely.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = tx_delay_q;
        cnt_dec      = 1'b0;
        case (state_q)
            ST_RX: begin
                if (transmit) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = tx_delay_q;
                    state_d      = (tx_delay_q == '0) ? ST_TX : ST_TX_DELAY;
                end
            end
            ST_TX_DELAY: begin
                if (!transmit)   state_d = ST_RX;
                else if (cnt_tc) state_d = ST_TX;
                else             cnt_dec = 1'b1;
            end
            ST_TX: begin
                if (!transmit) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = rx_delay_q;
                    state_d      = (rx_delay_q == '0) ? ST_RX : ST_RX_DELAY;
                end
            end
            ST_RX_DELAY: begin
                if (transmit)    state_d = ST_TX;
                else if (cnt_tc) state_d = ST_RX;
                else             cnt_dec = 1'b1;
            end
            default: state_d = ST_RX;
        endcase
    end

    atr_delay #(.DELAY_W(DELAY_W)) u_atr_delay (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    // Pins hold the previous direction's value until a delay expires.
    assign use_tx = (state_q == ST_TX) || (state_q == ST_RX_DELAY);

    always_comb begin
        reg_0_d = (mask_0_q & (use_tx ? txval_0_q : rxval_0_q)) | (~mask_0_q & io_0_q);
        reg_1_d = (mask_1_q & (use_tx ? txval_1_q : rxval_1_q)) | (~mask_1_q & io_1_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_0_q     <= '0;
            io_1_q     <= '0;
            mask_0_q   <= '0;
            mask_1_q   <= '0;
            txval_0_q  <= '0;
            txval_1_q  <= '0;
            rxval_0_q  <= '0;
            rxval_1_q  <= '0;
            tx_delay_q <= '0;
            rx_delay_q <= '0;
            reg_0_q    <= '0;
            reg_1_q    <= '0;
            state_q    <= ST_RX;
        end else begin
            io_0_q     <= io_0_d;
            io_1_q     <= io_1_d;
            mask_0_q   <= mask_0_d;
            mask_1_q   <= mask_1_d;
            txval_0_q  <= txval_0_d;
            txval_1_q  <= txval_1_d;
            rxval_0_q  <= rxval_0_d;
            rxval_1_q  <= rxval_1_d;
            tx_delay_q <= tx_delay_d;
            rx_delay_q <= rx_delay_d;
            reg_0_q    <= reg_0_d;
            reg_1_q    <= reg_1_d;
            state_q    <= state_d;
        end
    end

    assign reg_0     = reg_0_q;
    assign reg_1     = reg_1_q;
    assign atr_state = state_q;

endmodule

// File: tb/tb_atr_io_ctrl.sv
// Directed bench for atr_io_ctrl: register writes, ATR delays, aborts, reset.
module tb_atr_io_ctrl;
    import atr_io_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  serial_addr = '0;
    logic [31:0] serial_data = '0;
    logic        serial_strobe = 1'b0;
    logic        enable_tx = 1'b0;
    logic        tx_empty = 1'b0;
    logic [15:0] reg_0, reg_1;
    logic [1:0]  atr_state;

    int n_checks = 0;
    int n_errors = 0;

    atr_io_ctrl #(.DELAY_W(12)) dut (
        .clock         (clock),
        .reset         (reset),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .enable_tx     (enable_tx),
        .tx_empty      (tx_empty),
        .reg_0         (reg_0),
        .reg_1         (reg_1),
        .atr_state     (atr_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe lands on the posedge between the two negedges.
    task automatic wr(input logic [6:0] addr, input logic [31:0] data);
        @(negedge clock);
        serial_addr   = addr;
        serial_data   = data;
        serial_strobe = 1'b1;
        @(negedge clock);
        serial_strobe = 1'b0;
    endtask

    logic [1:0] exp_st [4] = '{2'd1, 2'd1, 2'd1, 2'd2};

    initial begin
        // Reset held across a clock edge
        @(negedge clock);
        chk("rst_reg0", reg_0, 0);
        chk("rst_reg1", reg_1, 0);
        chk("rst_state", atr_state, 0);
        reset = 1'b0;

        // Masked write to bank 0 manual value
        wr(FR_IO_0, 32'hFFFF_1234);
        wr(FR_IO_0, 32'h00FF_00A5);
        @(negedge clock);
        chk("masked_io0", reg_0, 16'h12A5);

        // ATR TX with delay 3
        wr(FR_ATR_MASK_0, 32'h0000_000F);
        wr(FR_ATR_TXVAL_0, 32'h0000_0005);
        wr(FR_ATR_RXVAL_0, 32'h0000_000A);
        wr(FR_ATR_TX_DELAY, 32'd3);
        @(negedge clock);
        chk("atr_rx_idle", reg_0, 16'h12AA);
        enable_tx = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk($sformatf("txd3_state%0d", k), atr_state, exp_st[k]);
            chk($sformatf("txd3_reg%0d", k), reg_0, 16'h12AA);
        end
        @(negedge clock);
        chk("txd3_reg_tx", reg_0, 16'h12A5);
        enable_tx = 1'b0;
        @(negedge clock);
        chk("rx0_state", atr_state, 0);
        chk("rx0_reg_hold", reg_0, 16'h12A5);
        @(negedge clock);
        chk("rx0_reg_rx", reg_0, 16'h12AA);

        // Abort TX_DELAY via underrun at count 5
        wr(FR_ATR_TX_DELAY, 32'd10);
        enable_tx = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk($sformatf("abort_state%0d", k), atr_state, 1);
            chk($sformatf("abort_reg%0d", k), reg_0, 16'h12AA);
        end
        tx_empty = 1'b1;
        @(negedge clock);
        chk("abort_to_rx", atr_state, 0);
        chk("abort_reg_a", reg_0, 16'h12AA);
        @(negedge clock);
        chk("abort_reg_b", reg_0, 16'h12AA);
        enable_tx = 1'b0;
        tx_empty  = 1'b0;

        // Zero delays on bank 1, with an I/O write on the same edge as the switch
        wr(FR_ATR_TX_DELAY, 32'd0);
        wr(FR_ATR_RX_DELAY, 32'd0);
        wr(FR_ATR_MASK_1, 32'h0000_FFFF);
        wr(FR_ATR_TXVAL_1, 32'h0000_BEEF);
        wr(FR_ATR_RXVAL_1, 32'h0000_1234);
        @(negedge clock);
        chk("zd_reg1_rx", reg_1, 16'h1234);
        enable_tx     = 1'b1;
        serial_addr   = FR_IO_0;
        serial_data   = 32'hFFFF_0000;
        serial_strobe = 1'b1;
        @(negedge clock);
        serial_strobe = 1'b0;
        chk("zd_state_tx", atr_state, 2);
        chk("zd_reg1_hold", reg_1, 16'h1234);
        @(negedge clock);
        chk("zd_reg1_tx", reg_1, 16'hBEEF);
        chk("coincide_reg0", reg_0, 16'h0005);
        enable_tx = 1'b0;
        @(negedge clock);
        chk("zd_state_rx", atr_state, 0);
        chk("zd_reg1_hold2", reg_1, 16'hBEEF);
        @(negedge clock);
        chk("zd_reg1_rx2", reg_1, 16'h1234);

        // RX_DELAY aborted by transmit re-asserting
        wr(FR_ATR_RX_DELAY, 32'd8);
        enable_tx = 1'b1;
        @(negedge clock);
        chk("rxd_state_tx", atr_state, 2);
        @(negedge clock);
        chk("rxd_reg_tx", reg_0, 16'h0005);
        enable_tx = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("rxd_state%0d", k), atr_state, 3);
            chk($sformatf("rxd_reg%0d", k), reg_0, 16'h0005);
        end
        enable_tx = 1'b1;
        @(negedge clock);
        chk("rxd_back_tx", atr_state, 2);
        chk("rxd_reg_a", reg_0, 16'h0005);
        @(negedge clock);
        chk("rxd_reg_b", reg_0, 16'h0005);

        // Reset asynchronously in the middle of TX_DELAY
        wr(FR_ATR_TX_DELAY, 32'd10);
        enable_tx = 1'b0;
        repeat (10) @(negedge clock);
        chk("pre_rst_rx", atr_state, 0);
        enable_tx = 1'b1;
        repeat (2) @(negedge clock);
        chk("pre_rst_txd", atr_state, 1);
        chk("pre_rst_reg0", reg_0, 16'h000A);
        #1 reset = 1'b1;
        #1;
        chk("arst_reg0", reg_0, 0);
        chk("arst_reg1", reg_1, 0);
        chk("arst_state", atr_state, 0);
        enable_tx = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("post_rst_reg0", reg_0, 0);
        chk("post_rst_reg1", reg_1, 0);
        chk("post_rst_state", atr_state, 0);
        // Default tx_delay of 0 means a direct jump to TX
        enable_tx = 1'b1;
        @(negedge clock);
        chk("post_rst_txdelay0", atr_state, 2);
        @(negedge clock);
        chk("post_rst_reg0_tx", reg_0, 0);
        enable_tx = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
